// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
package dmem_pkg;

  localparam int DATA_W        = 32;
  localparam int DEPTH_DEFAULT = 2048;
  // Wide enough for the largest legal latency (15).
  localparam int CNT_W         = $clog2(16);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, read-first, registered read data, contents not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = 11
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= wdata;
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked load/store memory target with fixed response latency.
// Build option: DMEM_BOUNDS_CHECK_EN flags and suppresses accesses with req_addr >= DEPTH.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int AW      = 11,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, resp_valid is a one-cycle pulse with no backpressure.
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q, oob_q, rd_keep, resp_err_q;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept, oob_req, commit, commit_we, commit_oob;
  logic [AW-1:0]     commit_idx;
  logic [DATA_W-1:0] commit_wdata, ram_rdata;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob_req = (req_addr >= 32'(DEPTH));
`else
  // Upper bits are dropped so addresses alias modulo DEPTH.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW];
  assign oob_req        = 1'b0;
`endif

  // The RAM operation happens on the edge that enters RESP.
  generate
    if (LATENCY == 1) begin : g_direct
      assign commit       = accept;
      assign commit_we    = req_we;
      assign commit_oob   = oob_req;
      assign commit_idx   = req_addr[AW-1:0];
      assign commit_wdata = req_wdata;
    end else begin : g_latched
      assign commit       = (state == WAIT) && (cnt == '0);
      assign commit_we    = we_q;
      assign commit_oob   = oob_q;
      assign commit_idx   = idx_q;
      assign commit_wdata = wdata_q;
    end
  endgenerate

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .en    (commit),
    .we    (commit_we && !commit_oob),
    .idx   (commit_idx),
    .wdata (commit_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      oob_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_err_q <= 1'b0;
      rd_keep    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err_q <= 1'b0;
      rd_keep    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            oob_q   <= oob_req;
            idx_q   <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
            if (LATENCY > 1) begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        state      <= RESP;
        resp_valid <= 1'b1;
        resp_err_q <= commit_oob;
        rd_keep    <= !commit_we && !commit_oob;
      end
    end
  end

  // Read data is forced to zero outside a successful read's response cycle.
  assign resp_rdata = rd_keep ? ram_rdata : '0;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance at LATENCY 2 and one at LATENCY 1.
module tb_dmem_responder;

  localparam int DEPTH = 2048;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk, rst;
  logic        req_valid [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        resp_valid[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];
  logic        busy      [2];

  dmem_responder #(.DEPTH(DEPTH), .AW(11), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .busy(busy[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .AW(11), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .busy(busy[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // Expected entry: {accept cycle[31:0], err, rdata[31:0]}
  logic [64:0] exp_q [2][$];
  logic [31:0] mdl   [2][DEPTH];

  function automatic int lat(input int s);
    return (s == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("%s_ready%0d", tag, s), 32'(req_ready[s]), 32'd1);
      check($sformatf("%s_valid%0d", tag, s), 32'(resp_valid[s]), 32'd0);
      check($sformatf("%s_rdata%0d", tag, s), resp_rdata[s], 32'd0);
      check($sformatf("%s_err%0d", tag, s), 32'(resp_err[s]), 32'd0);
      check($sformatf("%s_busy%0d", tag, s), 32'(busy[s]), 32'd0);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_exp(input int s, input int acc);
    int          idx;
    bit          oob;
    logic [31:0] rd;
    idx = int'(req_addr[s] % DEPTH);
    oob = BOUNDS && (req_addr[s] >= DEPTH);
    rd  = 32'd0;
    if (!oob) begin
      if (req_we[s]) mdl[s][idx] = req_wdata[s];
      else           rd = mdl[s][idx];
    end
    exp_q[s].push_back({32'(acc), oob, rd});
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_accept(input int s, input bit push, output int acc);
    acc = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (req_ready[s]) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check($sformatf("accept_timeout%0d", s), 32'd0, 32'd1);
    else if (push) push_exp(s, acc);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
  endtask

  // Request inputs are scrambled right after accept; the DUT must ignore them.
  task automatic release_req(input int s);
    req_valid[s] = 1'b0;
    req_we[s]    = 1'($urandom_range(0, 1));
    req_addr[s]  = $urandom;
    req_wdata[s] = $urandom;
  endtask

  task automatic issue(input int s, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    int acc;
    @(posedge clk);
    #1;
    drive(s, we, addr, wdata);
    wait_accept(s, 1'b1, acc);
    release_req(s);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++)
      @(negedge clk);
    check("drain_q0", 32'(exp_q[0].size()), 32'd0);
    check("drain_q1", 32'(exp_q[1].size()), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    for (int s = 0; s < 2; s++) begin
      if (!rst) begin
        check($sformatf("busy_vs_ready%0d", s), 32'(busy[s]), 32'(!req_ready[s]));
        if (resp_valid[s]) begin
          if (exp_q[s].size() == 0) begin
            check($sformatf("spurious_resp%0d", s), 32'd1, 32'd0);
          end else begin
            e = exp_q[s].pop_front();
            check($sformatf("latency%0d", s), 32'(cyc - int'(e[64:33])), 32'(lat(s)));
            check($sformatf("rdata%0d", s), resp_rdata[s], e[31:0]);
            check($sformatf("err%0d", s), 32'(resp_err[s]), {31'd0, e[32]});
          end
        end else begin
          check($sformatf("rdata_idle%0d", s), resp_rdata[s], 32'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int a0, a1, j, k;
    logic [31:0] addr;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_we[s]    = 1'b0;
      req_addr[s]  = 32'd0;
      req_wdata[s] = 32'd0;
    end
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic write/read at latency 2
    issue(0, 1'b1, 32'd0, 32'h0000_0006);
    issue(0, 1'b0, 32'd0, 32'd0);

    // Back-to-back reads with req_valid held high
    issue(0, 1'b1, 32'd1, 32'd3);
    issue(0, 1'b1, 32'd2, 32'd8);
    drain();
    @(posedge clk);
    #1;
    drive(0, 1'b0, 32'd1, 32'd0);
    wait_accept(0, 1'b1, a0);
    req_addr[0] = 32'd2;
    wait_accept(0, 1'b1, a1);
    release_req(0);
    check("b2b_spacing_lat2", 32'(a1 - a0), 32'd3);

    // Latency 1 write/read, also held back-to-back
    issue(1, 1'b1, 32'd5, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 32'd5, 32'd0);
    wait_accept(1, 1'b1, a0);
    wait_accept(1, 1'b1, a1);
    release_req(1);
    check("b2b_spacing_lat1", 32'(a1 - a0), 32'd2);

    // Reset during WAIT aborts an uncommitted write
    issue(0, 1'b1, 32'd5, 32'h0000_0002);
    drain();
    @(posedge clk);
    #1;
    drive(0, 1'b1, 32'd5, 32'h0000_0055);
    wait_accept(0, 1'b0, a0);
    release_req(0);
    check("busy_in_wait", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(0, 1'b0, 32'd5, 32'd0);

    // Out-of-range write, then read of the aliased index
    for (int s = 0; s < 2; s++) begin
      issue(s, 1'b1, 32'd0, 32'h0000_0011);
      issue(s, 1'b1, 32'h0000_0800, 32'h0000_0077);
      issue(s, 1'b0, 32'd0, 32'd0);
    end

    // Randomised traffic over a preloaded set near both ends of the array
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        issue(s, 1'b1, (i < 8) ? 32'(i) : 32'(2032 + i), $urandom);
    for (int n = 0; n < 60; n++) begin
      j    = $urandom_range(0, 15);
      k    = $urandom_range(0, 3);
      addr = 32'((j < 8) ? j : 2032 + j) + 32'(k * DEPTH);
      issue(n % 2, 1'($urandom_range(0, 1)), addr, $urandom);
    end

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
